// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding selects, load-use bubble,
// memory-wait and mul/div freezes, and mispredict flush for the in-order pipe.
module hazard_ctrl #(
  parameter int REG_NUM     = 32,
  parameter int STALL_CNT_W = 16,
  localparam int RW         = $clog2(REG_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RW-1:0]          id_rs1,
  input  logic [RW-1:0]          id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RW-1:0]          ex_rd,
  input  logic                   ex_wr_reg_en,
  input  logic                   ex_is_load,
  input  logic [RW-1:0]          mm_rd,
  input  logic                   mm_wr_reg_en,
  input  logic                   mm_is_load,
  input  logic                   mm_mem_ready,
  input  logic                   ex_md_start,
  input  logic                   md_done,
  input  logic                   br_mispredict,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   ex_hold,
  output logic                   mem_stall,
  output logic [1:0]             ex_rs1_sel,
  output logic [1:0]             ex_rs2_sel,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  state_t     state_q, state_nxt;
  logic [1:0] rs1_sel_nxt, rs2_sel_nxt;
  logic       load_use;
  logic       run_rules;

  // EX-stage producer wins over MM; x0 and unused sources never forward.
  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] rs,
    input logic          used,
    input logic [RW-1:0] e_rd,
    input logic          e_wr,
    input logic          e_ld,
    input logic [RW-1:0] m_rd,
    input logic          m_wr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (rs != '0)) begin
      if ((rs == e_rd) && e_wr)      sel = e_ld ? 2'b11 : 2'b10;
      else if ((rs == m_rd) && m_wr) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    rs1_sel_nxt = fwd_sel(id_rs1, id_rs1_used, ex_rd, ex_wr_reg_en, ex_is_load,
                          mm_rd, mm_wr_reg_en);
    rs2_sel_nxt = fwd_sel(id_rs2, id_rs2_used, ex_rd, ex_wr_reg_en, ex_is_load,
                          mm_rd, mm_wr_reg_en);
    load_use = ex_is_load && ex_wr_reg_en &&
               ((id_rs1_used && (id_rs1 != '0) && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 != '0) && (id_rs2 == ex_rd)));
  end

  always_comb begin
    state_nxt    = state_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    mem_stall    = 1'b0;
    run_rules    = 1'b0;

    case (state_q)
      RUN: run_rules = 1'b1;
      MEM_WAIT: begin
        if (!mm_mem_ready) begin
          mem_stall   = 1'b1;
          ex_hold     = 1'b1;
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
        end else begin
          // Released this cycle: a pending mispredict is handled right away.
          run_rules = 1'b1;
        end
      end
      MD_BUSY: begin
        if (!md_done) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          ex_hold     = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (run_rules) begin
      state_nxt = RUN;
      if (mm_is_load && !mm_mem_ready) begin
        mem_stall   = 1'b1;
        ex_hold     = 1'b1;
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        state_nxt   = MEM_WAIT;
      end else if (ex_md_start) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        ex_hold     = 1'b1;
        state_nxt   = MD_BUSY;
      end else if (br_mispredict) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ex_rs1_sel  <= 2'b00;
      ex_rs2_sel  <= 2'b00;
      stall_count <= '0;
    end else begin
      state_q <= state_nxt;
      if (!ex_hold) begin
        ex_rs1_sel <= id_ex_bubble ? 2'b00 : rs1_sel_nxt;
        ex_rs2_sel <= id_ex_bubble ? 2'b00 : rs2_sel_nxt;
      end
      if (pc_stall && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected EX selects are queued when the ID
// operands are driven and checked after the edge that moves them into EX.
module tb_hazard_ctrl;

  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd, mm_rd;
  logic          id_rs1_used, id_rs2_used, ex_wr_reg_en, ex_is_load;
  logic          mm_wr_reg_en, mm_is_load, mm_mem_ready;
  logic          ex_md_start, md_done, br_mispredict;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, mem_stall;
  logic [1:0]    ex_rs1_sel, ex_rs2_sel, state;
  logic [15:0]   stall_count;

  typedef struct {
    string      tag;
    logic [1:0] s1;
    logic [1:0] s2;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_cnt    = 0;

  hazard_ctrl #(.REG_NUM(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_wr_reg_en(ex_wr_reg_en), .ex_is_load(ex_is_load),
    .mm_rd(mm_rd), .mm_wr_reg_en(mm_wr_reg_en), .mm_is_load(mm_is_load),
    .mm_mem_ready(mm_mem_ready), .ex_md_start(ex_md_start), .md_done(md_done),
    .br_mispredict(br_mispredict),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .mem_stall(mem_stall),
    .ex_rs1_sel(ex_rs1_sel), .ex_rs2_sel(ex_rs2_sel),
    .stall_count(stall_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sel(input string tag, input logic [1:0] s1, input logic [1:0] s2);
    exp_t e;
    e.tag = tag; e.s1 = s1; e.s2 = s2;
    sbq.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sbq.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL sb_underflow: observed empty queue expected entry");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_rs1_sel"}, ex_rs1_sel, e.s1);
      chk({e.tag, "_rs2_sel"}, ex_rs2_sel, e.s2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = '0; ex_wr_reg_en = 1'b0; ex_is_load = 1'b0;
    mm_rd = '0; mm_wr_reg_en = 1'b0; mm_is_load = 1'b0; mm_mem_ready = 1'b1;
    ex_md_start = 1'b0; md_done = 1'b0; br_mispredict = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    chk("rst_state", state, 2'd0);
    chk("rst_rs1_sel", ex_rs1_sel, 2'b00);
    chk("rst_rs2_sel", ex_rs2_sel, 2'b00);
    chk("rst_count", stall_count, 16'd0);
    chk("rst_stalls", {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, mem_stall}, 6'b0);
    #9 rst_n = 1'b1;
    tick();

    // ALU forward from EX; x0 never forwards
    idle();
    id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    ex_rd = 5'd5; ex_wr_reg_en = 1'b1;
    #1;
    chk("fwd_alu_no_stall", {pc_stall, id_ex_bubble}, 2'b00);
    push_sel("fwd_alu", 2'b10, 2'b00);
    tick(); pop_chk();

    idle();
    id_rs1_used = 1'b1; id_rs2_used = 1'b1; ex_wr_reg_en = 1'b1;
    push_sel("x0_never", 2'b00, 2'b00);
    tick(); pop_chk();

    // unused source and MM forward, then EX-over-MM priority
    idle();
    id_rs1 = 5'd9; id_rs1_used = 1'b0; ex_rd = 5'd9; ex_wr_reg_en = 1'b1;
    id_rs2 = 5'd9; id_rs2_used = 1'b1;
    push_sel("unused_src", 2'b00, 2'b10);
    tick(); pop_chk();

    idle();
    id_rs1 = 5'd9; id_rs1_used = 1'b1; mm_rd = 5'd9; mm_wr_reg_en = 1'b1;
    id_rs2 = 5'd4; id_rs2_used = 1'b1; ex_rd = 5'd4; ex_wr_reg_en = 1'b1;
    push_sel("mm_and_prio", 2'b01, 2'b10);
    tick(); pop_chk();

    idle();
    id_rs2 = 5'd4; id_rs2_used = 1'b1; ex_rd = 5'd4; ex_wr_reg_en = 1'b1;
    mm_rd = 5'd4; mm_wr_reg_en = 1'b1;
    push_sel("ex_over_mm", 2'b00, 2'b10);
    tick(); pop_chk();

    // load-use: one bubble, then forward from WB-side path
    idle();
    ex_rd = 5'd7; ex_wr_reg_en = 1'b1; ex_is_load = 1'b1;
    id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #1;
    chk("lu_stalls", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold}, 5'b11100);
    exp_cnt++;
    push_sel("lu_bubble", 2'b00, 2'b00);
    tick(); pop_chk();
    chk("lu_count", stall_count, exp_cnt);

    idle();
    mm_rd = 5'd7; mm_wr_reg_en = 1'b1; mm_is_load = 1'b1;
    id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #1;
    chk("lu_release", {pc_stall, id_ex_bubble, mem_stall}, 3'b000);
    push_sel("lu_advance", 2'b00, 2'b01);
    tick(); pop_chk();
    chk("lu_count_hold", stall_count, exp_cnt);

    // mispredict overrides load-use
    idle();
    ex_rd = 5'd7; ex_wr_reg_en = 1'b1; ex_is_load = 1'b1;
    id_rs1 = 5'd7; id_rs1_used = 1'b1; br_mispredict = 1'b1;
    #1;
    chk("mp_lu", {if_id_flush, id_ex_bubble, pc_stall, if_id_stall}, 4'b1100);
    push_sel("mp_bubble", 2'b00, 2'b00);
    tick(); pop_chk();
    chk("mp_count", stall_count, exp_cnt);

    // memory wait for 3 cycles with a mispredict pending
    idle();
    ex_rd = 5'd3; ex_wr_reg_en = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    push_sel("mw_pre", 2'b10, 2'b00);
    tick(); pop_chk();

    idle();
    mm_is_load = 1'b1; mm_mem_ready = 1'b0; mm_rd = 5'd8; mm_wr_reg_en = 1'b1;
    id_rs1 = 5'd8; id_rs1_used = 1'b1; br_mispredict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stalls", {mem_stall, ex_hold, pc_stall, if_id_stall, if_id_flush, id_ex_bubble}, 6'b111100);
      exp_cnt++;
      push_sel("mw_hold", 2'b10, 2'b00);
      tick(); pop_chk();
      chk("mw_state", state, 2'd1);
    end
    mm_mem_ready = 1'b1;
    #1;
    chk("mw_ready", {mem_stall, ex_hold, pc_stall, if_id_stall, if_id_flush, id_ex_bubble}, 6'b000011);
    push_sel("mw_done", 2'b00, 2'b00);
    tick(); pop_chk();
    chk("mw_state_run", state, 2'd0);
    chk("mw_count", stall_count, exp_cnt);

    // mul/div busy for 4 cycles, MM not frozen
    idle();
    ex_rd = 5'd6; ex_wr_reg_en = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
    push_sel("md_pre", 2'b00, 2'b10);
    tick(); pop_chk();

    idle();
    ex_md_start = 1'b1; ex_rd = 5'd6; ex_wr_reg_en = 1'b1;
    id_rs1 = 5'd6; id_rs1_used = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("md_stalls", {ex_hold, pc_stall, if_id_stall, mem_stall}, 4'b1110);
      exp_cnt++;
      push_sel("md_hold", 2'b00, 2'b10);
      tick(); pop_chk();
      chk("md_state", state, 2'd2);
      ex_md_start = 1'b0;
    end
    md_done = 1'b1;
    #1;
    chk("md_done", {ex_hold, pc_stall, if_id_stall, mem_stall}, 4'b0000);
    push_sel("md_advance", 2'b10, 2'b00);
    tick(); pop_chk();
    chk("md_state_run", state, 2'd0);
    chk("md_count", stall_count, exp_cnt);

    // asynchronous reset while in MD_BUSY
    idle();
    ex_md_start = 1'b1;
    tick();
    chk("ar_state_busy", state, 2'd2);
    ex_md_start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", state, 2'd0);
    chk("ar_sels", {ex_rs1_sel, ex_rs2_sel}, 4'b0000);
    chk("ar_count", stall_count, 16'd0);
    exp_cnt = 0;
    #1 rst_n = 1'b1;
    tick();

    // saturation of the stall counter
    idle();
    ex_rd = 5'd7; ex_wr_reg_en = 1'b1; ex_is_load = 1'b1;
    id_rs1 = 5'd7; id_rs1_used = 1'b1;
    #1;
    chk("sat_stall", pc_stall, 1'b1);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_full", stall_count, 16'hFFFF);
    tick();
    chk("sat_hold", stall_count, 16'hFFFF);

    idle();
    tick();
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline hazard controller for the in-order integer pipeline. It computes the operand-forwarding selects for the EX-stage operand muxes. It detects load-use hazards and inserts one bubble. It sequences multi-cycle multiply/divide and memory-wait freezes, and issues flush/bubble on branch mispredict. It sits beside the ID/EX pipeline register and drives the stage stall, flush and hold enables.

Parameters:
REG_NUM, 32, number of architectural registers; RW = $clog2(REG_NUM) is the register-index width
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  RW each  source register indices of the instruction in ID
id_rs1_used, id_rs2_used  in  1 each  source is actually read
ex_rd  in  RW  destination of the instruction in EX
ex_wr_reg_en, ex_is_load  in  1 each  EX writes rd / EX is a load
mm_rd  in  RW  destination of the instruction in MM
mm_wr_reg_en, mm_is_load  in  1 each  MM writes rd / MM is a load
mm_mem_ready  in  1  load data valid this cycle (dcache)
ex_md_start  in  1  mul/div issued in EX this cycle
md_done  in  1  mul/div result valid this cycle
br_mispredict  in  1  EX branch resolved mispredicted (level)
pc_stall, if_id_stall  out  1 each  hold PC / hold IF/ID register
if_id_flush  out  1  squash IF/ID contents
id_ex_bubble  out  1  load NOP into ID/EX
ex_hold  out  1  hold ID/EX register and the EX stage
mem_stall  out  1  freeze EX/MM and MM/WB registers
ex_rs1_sel, ex_rs2_sel  out  2 each  registered forwarding selects for the instruction in EX
stall_count  out  STALL_CNT_W  cycles with pc_stall=1, saturating
state  out  2  FSM state (debug)

Behaviour:
- Reset: state=RUN, ex_rsX_sel=2'b00, stall_count=0. All stall, flush and bubble outputs are combinational and evaluate to 0 in RUN with idle inputs.
- Select encoding, applying to the operands of the instruction in EX:
  - 00 register file
  - 01 WB-stage value
  - 10 MM ALU result
  - 11 MM load data
- Registers with index 0 never match: x0 is never forwarded and never causes a stall.
- Select update: on every edge where ID advances into EX (ex_hold=0 and id_ex_bubble=0):
  - sel = 10 if rs==ex_rd & ex_wr_reg_en & !ex_is_load
  - else 11 if rs==ex_rd & ex_wr_reg_en & ex_is_load (only reachable with the load-use stall disabled; must not occur)
  - else 01 if rs==mm_rd & mm_wr_reg_en
  - else 00
  - An unused source forces 00. EX-stage match has priority over MM-stage match.
- On a bubble edge, selects load 00. On an ex_hold edge, selects hold.
- FSM states: RUN(0), MEM_WAIT(1), MD_BUSY(2). Encoding 3 is illegal and returns to RUN.
- RUN, priority high to low:
  1. mm_is_load & !mm_mem_ready: mem_stall=ex_hold=pc_stall=if_id_stall=1; next state MEM_WAIT.
  2. ex_md_start: pc_stall=if_id_stall=ex_hold=1; next state MD_BUSY.
  3. br_mispredict: if_id_flush=1, id_ex_bubble=1, no stall. Overrides a load-use hazard in the same cycle.
  4. Load-use (used id_rsX==ex_rd, ex_is_load, ex_wr_reg_en, index≠0): pc_stall=if_id_stall=1, id_ex_bubble=1 for exactly one cycle.
- MEM_WAIT: mem_stall, ex_hold, pc_stall and if_id_stall stay asserted while !mm_mem_ready. br_mispredict is ignored here (EX is frozen).
  - In the cycle mm_mem_ready=1, all four stalls deassert and state returns to RUN.
  - A mispredict still asserted is then acted on in that same cycle per the RUN rules.
- MD_BUSY: pc_stall, if_id_stall and ex_hold are asserted while !md_done. mem_stall=0, so MM and WB drain.
  - In the cycle md_done=1, the stalls deassert, the mul/div instruction advances, and the next state is RUN.
  - md_done together with ex_md_start in RUN is invalid (not checked).
- stall_count increments on every edge with pc_stall=1 and saturates at all-ones.
- Asynchronous reset mid-MEM_WAIT or mid-MD_BUSY: the FSM is forced to RUN immediately and selects clear to 00.

Test Plan:
- Forward ALU: EX add writes x5, ID reads rs1=x5 → next cycle ex_rs1_sel=10, no stall; rs2=x0 with ex_rd=0 → ex_rs2_sel=00.
- Load-use: EX load to x7, ID rs2=x7 → one cycle of pc_stall=if_id_stall=id_ex_bubble=1. Following edge: load in MM, ID advances with ex_rs2_sel=01. stall_count=1.
- Mispredict plus load-use in the same cycle → if_id_flush=1, id_ex_bubble=1, pc_stall=0.
- Memory wait: mm_is_load=1 with mm_mem_ready=0 for 3 cycles → mem_stall=1 for 3 cycles, state=MEM_WAIT, selects unchanged. Ready cycle: stalls=0, state→RUN, stall_count=3.
- Mul/div: ex_md_start, then md_done 4 cycles later → ex_hold=1 for 4 cycles, mem_stall=0, RUN after the md_done edge.
- Reset: rst_n low during MD_BUSY → state=RUN and selects=00 asynchronously. Saturation: preload 2^16-1 stalls, one more stall → stall_count stays 16'hFFFF.
